// File: rtl/uart_frame_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_bridge
// Description : Byte-UART to serial-bus bridge.
//               Host->bus : parses CMD, ADDR_HI, ADDR_LO, DATA frames into a
//                           master instruction and replies ACK_CODE/NAK_CODE.
//               Bus->host : forwards slave-written bytes to the host, waits
//                           for ACK_CODE, retries on timeout/bad reply and
//                           drops the byte after MAX_RETRY attempts.
// Option      : UART_FRAME_CHECKSUM_EN - frames carry a 5th byte equal to the
//               XOR of the first four; a mismatch is NAKed and not issued.
// Ports       : clk, reset (async, active-high)
//               m_*            : bus master command outputs, m_tx_done input
//               s_data,
//               s_write_en_in  : slave byte to forward to the host
//               u_*            : UART core handshake (rx bytes in, tx strobe)
//               drop_count,
//               nak_count      : saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_bridge #(
    parameter int          SLAVE_LEN     = 2,
    parameter int          ADDR_LEN      = 12,
    parameter int          BURST_LEN     = 12,
    parameter logic [7:0]  ACK_CODE      = 8'hCC,
    parameter logic [7:0]  NAK_CODE      = 8'h33,
    parameter int          MAX_COUNT     = 50000,
    parameter int          MAX_RETRY     = 5,
    parameter int          FRAME_TIMEOUT = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m_tx_done,
    output logic [1:0]           m_instruction,
    output logic [SLAVE_LEN-1:0] m_slave_select,
    output logic [ADDR_LEN-1:0]  m_address,
    output logic [7:0]           m_data_out,
    output logic [BURST_LEN-1:0] m_burst_num,
    input  logic [7:0]           s_data,
    input  logic                 s_write_en_in,
    input  logic                 u_tx_done,
    input  logic                 u_receive_sig,
    input  logic [7:0]           u_data_in,
    output logic                 u_send_sig,
    output logic [7:0]           u_data_out,
    output logic [7:0]           drop_count,
    output logic [7:0]           nak_count
);

    localparam int c_gap_w = $clog2(FRAME_TIMEOUT + 1);
    localparam int c_tmr_w = $clog2(MAX_COUNT + 1);
    localparam int c_try_w = $clog2(MAX_RETRY + 1);

    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(FRAME_TIMEOUT - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(MAX_COUNT - 1);
    localparam logic [c_try_w-1:0] c_try_max  = c_try_w'(MAX_RETRY);

    typedef enum logic [2:0] {
        P_CMD  = 3'd0,
        P_AH   = 3'd1,
        P_AL   = 3'd2,
        P_DATA = 3'd3,
        P_CK   = 3'd4
    } parse_state_t;

    typedef enum logic [0:0] {
        M_IDLE = 1'b0,
        M_OUT  = 1'b1
    } master_state_t;

    typedef enum logic [2:0] {
        T_IDLE     = 3'd0,
        T_REPLY    = 3'd1,
        T_DATA     = 3'd2,
        T_WAIT_ACK = 3'd3,
        T_HOLD     = 3'd4
    } tx_state_t;

    parse_state_t         r_p_state;
    master_state_t        r_m_state;
    tx_state_t            r_t_state;

    logic [c_gap_w-1:0]   r_gap;
    logic [7:0]           r_cmd;
    logic [7:0]           r_ah;
    logic [7:0]           r_al;
    logic [7:0]           r_data;
    logic                 r_frame_valid;

    logic                 r_pending;
    logic [7:0]           r_pending_code;
    logic [7:0]           r_byte;
    logic [c_try_w-1:0]   r_tries;
    logic [c_tmr_w-1:0]   r_timer;

    logic                 w_rx_byte;
    logic                 w_ck_ok;
    logic                 w_nak;
    logic                 w_issue;
    logic [7:0]           w_new_code;
    logic                 w_reply_valid;
    logic [7:0]           w_reply_code;
    logic                 w_ack_ok;
    logic                 w_ack_fail;
    logic [15:0]          w_addr_full;
    tx_state_t            w_after_tx;

`ifdef UART_FRAME_CHECKSUM_EN
    logic                 r_ck_ok;
    assign w_ck_ok = r_ck_ok;
`else
    assign w_ck_ok = 1'b1;
`endif

    // While waiting for the host's ACK, incoming bytes belong to the TX side.
    assign w_rx_byte = u_receive_sig && (r_t_state != T_WAIT_ACK);

    // ------------------------------------------------------------------
    // Frame parser
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p_state     <= P_CMD;
            r_gap         <= '0;
            r_cmd         <= 8'd0;
            r_ah          <= 8'd0;
            r_al          <= 8'd0;
            r_data        <= 8'd0;
            r_frame_valid <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
            r_ck_ok       <= 1'b0;
`endif
        end else begin
            r_frame_valid <= 1'b0;
            if (w_rx_byte) begin
                r_gap <= '0;
                case (r_p_state)
                    P_CMD: begin
                        r_cmd     <= u_data_in;
                        r_p_state <= P_AH;
                    end
                    P_AH: begin
                        r_ah      <= u_data_in;
                        r_p_state <= P_AL;
                    end
                    P_AL: begin
                        r_al      <= u_data_in;
                        r_p_state <= P_DATA;
                    end
                    P_DATA: begin
                        r_data <= u_data_in;
`ifdef UART_FRAME_CHECKSUM_EN
                        r_p_state <= P_CK;
`else
                        r_p_state     <= P_CMD;
                        r_frame_valid <= 1'b1;
`endif
                    end
                    default: begin
`ifdef UART_FRAME_CHECKSUM_EN
                        r_ck_ok       <= ((r_cmd ^ r_ah ^ r_al ^ r_data) == u_data_in);
                        r_frame_valid <= 1'b1;
`endif
                        r_p_state     <= P_CMD;
                    end
                endcase
            end else if (r_p_state != P_CMD) begin
                // A stalled partial frame is discarded without any reply.
                if (r_gap == c_gap_last) begin
                    r_p_state <= P_CMD;
                    r_gap     <= '0;
                end else begin
                    r_gap <= r_gap + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame completion decision (valid for one cycle after the last byte)
    // ------------------------------------------------------------------
    assign w_nak       = (r_m_state == M_OUT) || !w_ck_ok;
    assign w_new_code  = w_nak ? NAK_CODE : ACK_CODE;
    assign w_issue     = r_frame_valid && !w_nak && (r_cmd[7:6] != 2'b00);
    assign w_addr_full = {r_ah, r_al};

    // ------------------------------------------------------------------
    // Master FSM and NAK counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m_state      <= M_IDLE;
            m_instruction  <= 2'b00;
            m_slave_select <= SLAVE_LEN'(1);
            m_address      <= '0;
            m_data_out     <= 8'd0;
            nak_count      <= 8'd0;
        end else begin
            if (r_frame_valid && w_nak && (nak_count != 8'hFF)) begin
                nak_count <= nak_count + 8'd1;
            end
            case (r_m_state)
                M_IDLE: begin
                    if (w_issue) begin
                        m_instruction  <= r_cmd[7:6];
                        m_slave_select <= r_cmd[SLAVE_LEN-1:0];
                        m_address      <= w_addr_full[ADDR_LEN-1:0];
                        m_data_out     <= r_data;
                        r_m_state      <= M_OUT;
                    end
                end
                default: begin
                    if (m_tx_done) begin
                        m_instruction <= 2'b00;
                        r_m_state     <= M_IDLE;
                    end
                end
            endcase
        end
    end

    assign m_burst_num = '0;

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    // A reply produced this cycle is usable immediately so an idle
    // transmitter strobes the ACK two cycles after the final byte.
    assign w_reply_valid = r_pending || r_frame_valid;
    assign w_reply_code  = r_frame_valid ? w_new_code : r_pending_code;

    assign w_ack_ok   = u_receive_sig && (u_data_in == ACK_CODE);
    assign w_ack_fail = u_receive_sig ? (u_data_in != ACK_CODE) : (r_timer == c_tmr_last);
    assign w_after_tx = s_write_en_in ? T_HOLD : T_IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_t_state      <= T_IDLE;
            r_pending      <= 1'b0;
            r_pending_code <= 8'd0;
            r_byte         <= 8'd0;
            r_tries        <= '0;
            r_timer        <= '0;
            u_send_sig     <= 1'b0;
            u_data_out     <= 8'd0;
            drop_count     <= 8'd0;
        end else begin
            u_send_sig <= 1'b0;
            // Only one reply can wait; a newer one replaces an older one.
            if (r_frame_valid && (r_t_state != T_IDLE)) begin
                r_pending      <= 1'b1;
                r_pending_code <= w_new_code;
            end
            case (r_t_state)
                T_IDLE: begin
                    if (w_reply_valid) begin
                        u_data_out <= w_reply_code;
                        u_send_sig <= 1'b1;
                        r_pending  <= 1'b0;
                        r_t_state  <= T_REPLY;
                    end else if (s_write_en_in) begin
                        r_byte     <= s_data;
                        u_data_out <= s_data;
                        u_send_sig <= 1'b1;
                        r_tries    <= '0;
                        r_t_state  <= T_DATA;
                    end
                end
                T_REPLY: begin
                    if (u_tx_done) begin
                        r_t_state <= T_IDLE;
                    end
                end
                T_DATA: begin
                    if (u_tx_done) begin
                        r_tries   <= r_tries + 1'b1;
                        r_timer   <= '0;
                        r_t_state <= T_WAIT_ACK;
                    end
                end
                T_WAIT_ACK: begin
                    if (w_ack_ok) begin
                        r_t_state <= w_after_tx;
                    end else if (w_ack_fail) begin
                        if (r_tries < c_try_max) begin
                            u_data_out <= r_byte;
                            u_send_sig <= 1'b1;
                            r_t_state  <= T_DATA;
                        end else begin
                            if (drop_count != 8'hFF) begin
                                drop_count <= drop_count + 8'd1;
                            end
                            r_t_state <= w_after_tx;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                T_HOLD: begin
                    if (!s_write_en_in) begin
                        r_t_state <= T_IDLE;
                    end
                end
                default: begin
                    r_t_state <= T_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_bridge
// Description : Self-checking bench for uart_frame_bridge with randomized
//               frames and slave bytes against a frame-level reference model.
//               Define UART_FRAME_CHECKSUM_EN to exercise 5-byte frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_bridge;

    localparam int SL     = 2;
    localparam int AL     = 12;
    localparam int BL     = 12;
    localparam int MC     = 40;
    localparam int MR     = 5;
    localparam int FT     = 60;
    localparam int TX_DLY = 3;
    localparam logic [7:0] ACK = 8'hCC;
    localparam logic [7:0] NAK = 8'h33;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m_tx_done = 1'b0;
    logic [1:0]    m_instruction;
    logic [SL-1:0] m_slave_select;
    logic [AL-1:0] m_address;
    logic [7:0]    m_data_out;
    logic [BL-1:0] m_burst_num;
    logic [7:0]    s_data = 8'd0;
    logic          s_write_en_in = 1'b0;
    logic          u_tx_done = 1'b0;
    logic          u_receive_sig = 1'b0;
    logic [7:0]    u_data_in = 8'd0;
    logic          u_send_sig;
    logic [7:0]    u_data_out;
    logic [7:0]    drop_count;
    logic [7:0]    nak_count;

    always #5 clk = ~clk;

    uart_frame_bridge #(
        .SLAVE_LEN(SL), .ADDR_LEN(AL), .BURST_LEN(BL),
        .ACK_CODE(ACK), .NAK_CODE(NAK),
        .MAX_COUNT(MC), .MAX_RETRY(MR), .FRAME_TIMEOUT(FT)
    ) dut (
        .clk(clk), .reset(reset), .m_tx_done(m_tx_done),
        .m_instruction(m_instruction), .m_slave_select(m_slave_select),
        .m_address(m_address), .m_data_out(m_data_out), .m_burst_num(m_burst_num),
        .s_data(s_data), .s_write_en_in(s_write_en_in),
        .u_tx_done(u_tx_done), .u_receive_sig(u_receive_sig), .u_data_in(u_data_in),
        .u_send_sig(u_send_sig), .u_data_out(u_data_out),
        .drop_count(drop_count), .nak_count(nak_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transmit log: every strobe with its byte and cycle stamp.
    logic [7:0] q_sent[$];
    int         q_time[$];
    int         cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (u_send_sig === 1'b1) begin
                q_sent.push_back(u_data_out);
                q_time.push_back(cyc);
            end
        end
    end

    // UART core model: each strobe completes TX_DLY cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (u_send_sig === 1'b1) begin
                repeat (TX_DLY) @(negedge clk);
                u_tx_done = 1'b1;
                @(negedge clk);
                u_tx_done = 1'b0;
            end
        end
    end

    // Reference model state
    bit            e_busy = 0;
    logic [1:0]    e_instr = 2'd0;
    logic [SL-1:0] e_ss = SL'(1);
    logic [AL-1:0] e_addr = '0;
    logic [7:0]    e_data = 8'd0;
    int            e_nak = 0;
    int            e_drop = 0;
    logic [7:0]    e_reply = 8'd0;

    task automatic model_reset();
        e_busy = 0; e_instr = 2'd0; e_ss = SL'(1); e_addr = '0; e_data = 8'd0;
        e_nak = 0; e_drop = 0;
    endtask

    task automatic model_frame(input logic [7:0] c, ah, al, d, input bit bad);
        bit ck_ok;
        int a;
        ck_ok = 1;
`ifdef UART_FRAME_CHECKSUM_EN
        ck_ok = !bad;
`endif
        if (e_busy || !ck_ok) begin
            e_reply = NAK;
            if (e_nak < 255) e_nak++;
        end else begin
            e_reply = ACK;
            if ((c / 64) != 0) begin
                a       = (ah * 256 + al) % (1 << AL);
                e_instr = 2'(c / 64);
                e_ss    = SL'(c % (1 << SL));
                e_addr  = AL'(a);
                e_data  = d;
                e_busy  = 1;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        u_receive_sig = 1'b1;
        u_data_in     = b;
        @(negedge clk);
        u_receive_sig = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, ah, al, d, input bit bad);
        logic [7:0] fb[5];
        int nb;
        fb[0] = c; fb[1] = ah; fb[2] = al; fb[3] = d;
        fb[4] = c ^ ah ^ al ^ d ^ (bad ? 8'h5A : 8'h00);
        nb = 4;
`ifdef UART_FRAME_CHECKSUM_EN
        nb = 5;
`endif
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(fb[i]);
        end
    endtask

    task automatic wait_sends(input string tag, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q_sent.size() >= n) break;
            @(negedge clk);
        end
        check(tag, q_sent.size(), n);
    endtask

    task automatic master_done();
        @(negedge clk);
        m_tx_done = 1'b1;
        @(negedge clk);
        m_tx_done = 1'b0;
        e_busy  = 0;
        e_instr = 2'd0;
    endtask

    task automatic check_master(input string tag);
        check({tag, "_instr"}, m_instruction, e_instr);
        check({tag, "_ss"},    m_slave_select, e_ss);
        check({tag, "_addr"},  m_address, e_addr);
        check({tag, "_data"},  m_data_out, e_data);
        check({tag, "_burst"}, m_burst_num, 0);
        check({tag, "_nak"},   nak_count, e_nak);
        check({tag, "_drop"},  drop_count, e_drop);
    endtask

    task automatic do_frame(input string tag, input logic [7:0] c, ah, al, d, input bit bad);
        logic [7:0] got;
        q_sent.delete(); q_time.delete();
        send_frame(c, ah, al, d, bad);
        model_frame(c, ah, al, d, bad);
        wait_sends({tag, "_reply_seen"}, 1, TX_DLY + 12);
        repeat (TX_DLY + 4) @(negedge clk);
        got = (q_sent.size() > 0) ? q_sent[0] : 8'h00;
        check({tag, "_reply_cnt"}, q_sent.size(), 1);
        check({tag, "_reply"}, got, e_reply);
        check_master(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"}, m_instruction, 0);
        check({tag, "_ss"},    m_slave_select, 1);
        check({tag, "_addr"},  m_address, 0);
        check({tag, "_data"},  m_data_out, 0);
        check({tag, "_burst"}, m_burst_num, 0);
        check({tag, "_send"},  u_send_sig, 0);
        check({tag, "_dout"},  u_data_out, 0);
        check({tag, "_drop"},  drop_count, 0);
        check({tag, "_nak"},   nak_count, 0);
    endtask

    initial begin
        logic [7:0] sb;
        int gap, base;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Directed frame with ACK latency check
        q_sent.delete(); q_time.delete();
        send_frame(8'h81, 8'h01, 8'h23, 8'h5A, 0);
        model_frame(8'h81, 8'h01, 8'h23, 8'h5A, 0);
        @(negedge clk);
        check("ack_latency", u_send_sig, 1);
        check("ack_byte", u_data_out, ACK);
        repeat (TX_DLY + 6) @(negedge clk);
        check("dir_reply_cnt", q_sent.size(), 1);
        check_master("dir");
        repeat (20) @(negedge clk);
        check("dir_instr_hold", m_instruction, 2'b10);

        // Second frame while master busy: NAK, outputs unchanged
        do_frame("busy", 8'hC3, 8'h0F, 8'hFF, 8'h77, 0);
        master_done();
        repeat (2) @(negedge clk);
        check_master("done");

        // Randomized frames
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1) master_done();
            do_frame("rnd", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);
        end

        // Partial frame abandoned by the inter-byte timeout
        master_done();
        q_sent.delete(); q_time.delete();
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        repeat (FT + 5) @(negedge clk);
        check("partial_silent", q_sent.size(), 0);
        do_frame("after_to", 8'h42, 8'($urandom), 8'($urandom), 8'($urandom), 0);
        master_done();

        // Slave byte ACKed on first attempt, then held while enable stays high
        q_sent.delete(); q_time.delete();
        sb = 8'h42;
        s_data = sb;
        s_write_en_in = 1'b1;
        wait_sends("sw_first", 1, 10);
        repeat (TX_DLY + 3) @(negedge clk);
        send_byte(ACK);
        repeat (2 * MC + 10) @(negedge clk);
        check("sw_ack_cnt", q_sent.size(), 1);
        check("sw_ack_byte", (q_sent.size() > 0) ? q_sent[0] : 8'h00, sb);
        s_write_en_in = 1'b0;
        s_data = 8'($urandom);
        repeat (MC) @(negedge clk);
        check("sw_ack_after_fall", q_sent.size(), 1);

        // No host ACK: MR attempts spaced by one timeout, then dropped
        q_sent.delete(); q_time.delete();
        sb = 8'($urandom);
        s_data = sb;
        s_write_en_in = 1'b1;
        wait_sends("noack_all", MR, MR * (MC + TX_DLY + 8));
        repeat (MC + TX_DLY + 10) @(negedge clk);
        check("noack_cnt", q_sent.size(), MR);
        for (int i = 0; i < q_sent.size(); i++) check("noack_byte", q_sent[i], sb);
        for (int i = 1; i < q_time.size(); i++) begin
            gap = q_time[i] - q_time[i-1];
            check("noack_gap_ok", (gap >= MC + TX_DLY && gap <= MC + TX_DLY + 2), 1);
        end
        e_drop++;
        check("noack_drop", drop_count, e_drop);
        s_write_en_in = 1'b0;
        repeat (3) @(negedge clk);

        // Bad reply byte forces an immediate retransmit
        q_sent.delete(); q_time.delete();
        sb = 8'($urandom);
        s_data = sb;
        s_write_en_in = 1'b1;
        wait_sends("bad_first", 1, 10);
        repeat (TX_DLY + 3) @(negedge clk);
        send_byte(8'h00);
        wait_sends("bad_resend", 2, 6);
        gap = (q_time.size() >= 2) ? q_time[1] - q_time[0] : MC;
        check("bad_resend_fast", (gap < MC), 1);
        repeat (TX_DLY + 3) @(negedge clk);
        send_byte(ACK);
        repeat (2 * MC) @(negedge clk);
        check("bad_total", q_sent.size(), 2);
        check("bad_byte", (q_sent.size() >= 2) ? q_sent[1] : 8'h00, sb);
        check("bad_drop", drop_count, e_drop);
        s_write_en_in = 1'b0;
        repeat (3) @(negedge clk);

        // Parser still aligned after host bytes consumed as ACK replies
        do_frame("align", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);
        master_done();

`ifdef UART_FRAME_CHECKSUM_EN
        do_frame("badck", 8'h81, 8'h01, 8'h23, 8'h5A, 1);
        do_frame("goodck", 8'h81, 8'h01, 8'h23, 8'h5A, 0);
        master_done();
`endif

        // Reset while waiting for the host ACK
        do_frame("pre_rst", 8'hC2, 8'($urandom), 8'($urandom), 8'($urandom), 0);
        q_sent.delete(); q_time.delete();
        s_data = 8'($urandom);
        s_write_en_in = 1'b1;
        wait_sends("rst_first", 1, 10);
        repeat (TX_DLY + 3) @(negedge clk);
        reset = 1'b1;
        s_write_en_in = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        base = q_sent.size();
        repeat (3 * MC) @(negedge clk);
        check("midrst_no_send", q_sent.size(), base);
        check_master("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_bridge.md
Name: uart_frame_bridge

Overview:
- Bridges a byte UART to the serial bus master and slave ports.
- Host→bus: parses multi-byte command frames into a master instruction, slave select, address and data, then replies with an ACK or NAK byte.
- Bus→host: sends each slave-written byte to the host, waits for an ACK, retries on timeout or bad ACK, and drops the byte after a bounded number of attempts.
- Sits between the UART core and the bus master/slave interfaces; UART byte width is fixed at 8.

Parameters:
- SLAVE_LEN, 2, width of m_slave_select (≤6).
- ADDR_LEN, 12, width of m_address (≤16).
- BURST_LEN, 12, width of m_burst_num.
- ACK_CODE, 8'hCC, acknowledge byte.
- NAK_CODE, 8'h33, negative-acknowledge byte.
- MAX_COUNT, 50000, ACK-wait timeout in clk cycles.
- MAX_RETRY, 5, total transmit attempts per slave byte.
- FRAME_TIMEOUT, 100000, inter-byte gap in cycles that aborts a partial frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- m_tx_done  in  1  master finished current instruction (1-cycle pulse).
- m_instruction  out  2  master instruction; 00 = idle.
- m_slave_select  out  SLAVE_LEN  target slave.
- m_address  out  ADDR_LEN  target address.
- m_data_out  out  8  write data.
- m_burst_num  out  BURST_LEN  burst length; always 0.
- s_data  in  8  slave byte to forward to the host.
- s_write_en_in  in  1  slave write request (level).
- u_tx_done  in  1  UART byte sent (pulse).
- u_receive_sig  in  1  UART byte received (pulse).
- u_data_in  in  8  received byte.
- u_send_sig  out  1  1-cycle transmit strobe.
- u_data_out  out  8  byte to transmit.
- drop_count  out  8  saturating count of bus→host bytes dropped after MAX_RETRY attempts.
- nak_count  out  8  saturating count of NAKs sent.

Behaviour:
- Reset: all outputs 0 except m_slave_select = 1; every FSM goes to its idle state; counters cleared. Reset mid-operation abandons any transfer with no further strobes.
- Frame format: CMD, ADDR_HI, ADDR_LO, DATA.
  - CMD[7:6] gives the instruction; CMD[SLAVE_LEN-1:0] gives the slave select.
  - Address = {ADDR_HI, ADDR_LO}[ADDR_LEN-1:0].
- Parser FSM: P_CMD → P_AH → P_AL → P_DATA, advancing one state per u_receive_sig.
  - The gap counter clears on each byte. On reaching FRAME_TIMEOUT, the parser returns to P_CMD and discards the partial frame silently.
  - CMD with instruction 00: frame is accepted and ACKed, but nothing is issued to the master.
  - Received bytes go to the parser only while the TX FSM is not in T_WAIT_ACK.
- Frame complete: on the cycle after the DATA byte, load the master outputs and queue an ACK.
  - If the master FSM is still busy, the frame is dropped, a NAK is queued and nak_count increments.
- Master FSM: M_IDLE → M_OUT when a frame is loaded; m_instruction is held until m_tx_done, then returns to 00 and the FSM goes back to M_IDLE. Address and data outputs hold their last values.
- TX FSM states: T_IDLE, T_REPLY, T_DATA, T_WAIT_ACK, T_HOLD.
  - T_IDLE priority: pending ACK/NAK reply first, then s_write_en_in. One reply is pending at most; a newer reply overwrites an older one.
  - Reply path: u_data_out = reply byte, u_send_sig high for 1 cycle, go to T_REPLY. Wait for u_tx_done, then return to T_IDLE.
  - Data path: latch s_data, strobe, go to T_DATA. On u_tx_done, increment attempt count and go to T_WAIT_ACK with the timer cleared.
  - T_WAIT_ACK, byte == ACK_CODE: success.
  - T_WAIT_ACK, any other byte, or timer reaches MAX_COUNT: retransmit the same byte (strobe, go to T_DATA) if attempts < MAX_RETRY. Otherwise drop the byte and increment drop_count.
  - Success or drop: go to T_HOLD if s_write_en_in is still 1, else T_IDLE. T_HOLD returns to T_IDLE when s_write_en_in = 0.
- Counters saturate at 255.
- Latency: ACK strobe is 2 cycles after the final frame byte's u_receive_sig, given TX is idle.

Optional Feature:
- Macro UART_FRAME_CHECKSUM_EN.
- Defined: frame has a 5th byte equal to the XOR of the first four.
  - Match: normal processing.
  - Mismatch: no master issue, NAK queued, nak_count increments.
- Undefined: 4-byte frames, no checksum check.

Test Plan:
- Frame 8'h81, 8'h01, 8'h23, 8'h5A → m_instruction = 10, m_slave_select = 1, m_address = 12'h123, m_data_out = 8'h5A until m_tx_done; u_data_out = 8'hCC strobed once.
- s_write_en_in with s_data = 8'h42; host answers 8'hCC after the first send → exactly one transmit; state waits in T_HOLD until s_write_en_in falls.
- No host ACK → 5 transmits of 8'h42 spaced MAX_COUNT cycles apart, then drop_count = 1; a reply of 8'h00 triggers an immediate retransmit.
- Two bytes, then an idle gap longer than FRAME_TIMEOUT, then a full frame → only the second frame issued, one ACK.
- Second frame completing before m_tx_done → NAK 8'h33 sent, nak_count = 1, first frame's outputs unchanged.
- Reset asserted during T_WAIT_ACK → all outputs reset values, no further u_send_sig; with UART_FRAME_CHECKSUM_EN defined, a bad checksum → NAK and no master activity.
